// File: rtl/fft_job_scheduler.sv
// Arbitrates forward/inverse requesters onto one FFT core: config beat, FFT_LEN samples, wait for output tlast.
// Latency: 1 cycle IDLE->CFG; LOAD is a combinational pass-through; DONE is one cycle after output tlast.
// Backpressure: cfg held until cfg_tready, granted ready mirrors data_tready; FFT_SCHED_FWD_PRIORITY_EN selects fixed priority.
module fft_job_scheduler #(
    parameter int FFT_LEN       = 1024,
    parameter int LEN_BITS      = 10,
    parameter int DATA_W        = 16,
    parameter int FRAME_CNT_W   = 6,
    parameter int FRAME_CNT_MAX = 44,
    parameter int TIMEOUT       = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fwd_req,
    input  logic                     fwd_valid,
    input  logic [2*DATA_W-1:0]      fwd_data,
    output logic                     fwd_ready,
    input  logic                     inv_req,
    input  logic                     inv_valid,
    input  logic [2*DATA_W-1:0]      inv_data,
    output logic                     inv_ready,
    output logic                     xn_axi4s_cfg_tvalid,
    output logic                     xn_axi4s_cfg_tdata,
    input  logic                     xn_axi4s_cfg_tready,
    output logic                     xn_axi4s_data_tvalid,
    output logic [63:0]              xn_axi4s_data_tdata,
    output logic                     xn_axi4s_data_tlast,
    input  logic                     xn_axi4s_data_tready,
    input  logic                     xk_axi4s_data_tvalid,
    input  logic                     xk_axi4s_data_tlast,
    output logic                     grant_fwd,
    output logic                     grant_inv,
    output logic                     fwd_done,
    output logic                     inv_done,
    output logic [FRAME_CNT_W-1:0]   frame_cnt,
    output logic                     timeout_err,
    input  logic                     err_clr
);

    localparam int TMO_W = $clog2(TIMEOUT);
    localparam logic [LEN_BITS-1:0]    LAST_IDX   = LEN_BITS'(FFT_LEN - 1);
    localparam logic [TMO_W-1:0]       TMO_LAST   = TMO_W'(TIMEOUT - 1);
    localparam logic [FRAME_CNT_W-1:0] FRAME_LAST = FRAME_CNT_W'(FRAME_CNT_MAX);

    typedef enum logic [2:0] {IDLE, CFG, LOAD, WAIT_OUT, DONE} state_t;

    state_t              state, state_nxt;
    logic                sel_inv, sel_inv_nxt;
    logic                last_inv;
    logic                pick_inv;
    logic [LEN_BITS-1:0] sample_cnt;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [2*DATA_W-1:0] src_data;
    logic                src_valid;
    logic                beat;
    logic                frame_end;
    logic                out_end;
    logic                tmo_hit;

`ifdef FFT_SCHED_FWD_PRIORITY_EN
    assign pick_inv = inv_req & ~fwd_req;
`else
    // On a tie, the inverse side wins only if forward was served last
    assign pick_inv = inv_req & (~fwd_req | ~last_inv);
`endif

    assign src_valid = sel_inv ? inv_valid : fwd_valid;
    assign src_data  = sel_inv ? inv_data  : fwd_data;
    assign beat      = (state == LOAD) && src_valid && xn_axi4s_data_tready;
    assign frame_end = beat && (sample_cnt == LAST_IDX);
    assign out_end   = xk_axi4s_data_tvalid && xk_axi4s_data_tlast;
    assign tmo_hit   = (state == WAIT_OUT) && !out_end && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sel_inv <= 1'b0;
        end else begin
            state   <= state_nxt;
            sel_inv <= sel_inv_nxt;
        end
    end

    always_comb begin
        state_nxt            = state;
        sel_inv_nxt          = sel_inv;
        xn_axi4s_cfg_tvalid  = 1'b0;
        xn_axi4s_cfg_tdata   = 1'b0;
        xn_axi4s_data_tvalid = 1'b0;
        xn_axi4s_data_tdata  = '0;
        xn_axi4s_data_tlast  = 1'b0;
        fwd_ready            = 1'b0;
        inv_ready            = 1'b0;
        fwd_done             = 1'b0;
        inv_done             = 1'b0;
        grant_fwd            = (state != IDLE) && !sel_inv;
        grant_inv            = (state != IDLE) && sel_inv;
        case (state)
            IDLE: begin
                if (fwd_req || inv_req) begin
                    state_nxt   = CFG;
                    sel_inv_nxt = pick_inv;
                end
            end
            CFG: begin
                xn_axi4s_cfg_tvalid = 1'b1;
                xn_axi4s_cfg_tdata  = !sel_inv;
                if (xn_axi4s_cfg_tready) state_nxt = LOAD;
            end
            LOAD: begin
                xn_axi4s_data_tvalid = src_valid;
                xn_axi4s_data_tdata  = {{(32-DATA_W){src_data[2*DATA_W-1]}}, src_data[2*DATA_W-1:DATA_W],
                                        {(32-DATA_W){src_data[DATA_W-1]}},   src_data[DATA_W-1:0]};
                xn_axi4s_data_tlast  = (sample_cnt == LAST_IDX);
                fwd_ready            = !sel_inv && xn_axi4s_data_tready;
                inv_ready            = sel_inv && xn_axi4s_data_tready;
                if (frame_end) state_nxt = WAIT_OUT;
            end
            WAIT_OUT: begin
                if (out_end)      state_nxt = DONE;
                else if (tmo_hit) state_nxt = IDLE;
            end
            DONE: begin
                fwd_done  = !sel_inv;
                inv_done  = sel_inv;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt  <= '0;
            tmo_cnt     <= '0;
            last_inv    <= 1'b1;
            frame_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (beat) sample_cnt <= frame_end ? '0 : sample_cnt + 1'b1;
            tmo_cnt <= (state == WAIT_OUT) ? tmo_cnt + 1'b1 : '0;
            // A timed-out job still counts as served for fairness
            if (state == DONE || tmo_hit) last_inv <= sel_inv;
            if (state == DONE && !sel_inv)
                frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 1'b1;
            if (tmo_hit)      timeout_err <= 1'b1;
            else if (err_clr) timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_job_scheduler.sv
// Directed bench for fft_job_scheduler: forward/inverse jobs, arbitration, backpressure, frame wrap, timeout, reset abort.
module tb_fft_job_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fwd_req = 1'b0, fwd_valid = 1'b0, fwd_ready;
    logic [31:0] fwd_data = 32'h8001_7FFE;
    logic        inv_req = 1'b0, inv_valid = 1'b0, inv_ready;
    logic [31:0] inv_data = 32'h1234_FFFF;
    logic        cfg_tvalid, cfg_tdata, cfg_tready = 1'b0;
    logic        data_tvalid, data_tlast, data_tready = 1'b1;
    logic [63:0] data_tdata;
    logic        xk_tvalid = 1'b0, xk_tlast = 1'b0;
    logic        grant_fwd, grant_inv, fwd_done, inv_done, timeout_err;
    logic        err_clr = 1'b0;
    logic [5:0]  frame_cnt;

    logic        tog_en = 1'b0;
    logic        core_mute = 1'b0;

    int n_checks = 0, n_errors = 0;
    int cyc = 0, fbeat = 0;
    int n_beats = 0, n_tlast = 0, n_tlast_bad = 0, n_cfg_cyc = 0;
    int n_fwd_done = 0, n_inv_done = 0, n_onehot_bad = 0, n_inv_rdy = 0;
    int tlast_cyc = 0, err_cyc = 0;
    logic        err_prev = 1'b0;
    logic [7:0]  cfg_hist = '0;
    logic [63:0] last_data = '0;

    int s_beats, s_tlast, s_tlast_bad, s_cfg, s_fwd, s_inv, s_onehot, s_invrdy;
    logic [3:0] order;
    bit         was_fwd;

    fft_job_scheduler dut (
        .clk                  (clk),
        .rst                  (rst),
        .fwd_req              (fwd_req),
        .fwd_valid            (fwd_valid),
        .fwd_data             (fwd_data),
        .fwd_ready            (fwd_ready),
        .inv_req              (inv_req),
        .inv_valid            (inv_valid),
        .inv_data             (inv_data),
        .inv_ready            (inv_ready),
        .xn_axi4s_cfg_tvalid  (cfg_tvalid),
        .xn_axi4s_cfg_tdata   (cfg_tdata),
        .xn_axi4s_cfg_tready  (cfg_tready),
        .xn_axi4s_data_tvalid (data_tvalid),
        .xn_axi4s_data_tdata  (data_tdata),
        .xn_axi4s_data_tlast  (data_tlast),
        .xn_axi4s_data_tready (data_tready),
        .xk_axi4s_data_tvalid (xk_tvalid),
        .xk_axi4s_data_tlast  (xk_tlast),
        .grant_fwd            (grant_fwd),
        .grant_inv            (grant_inv),
        .fwd_done             (fwd_done),
        .inv_done             (inv_done),
        .frame_cnt            (frame_cnt),
        .timeout_err          (timeout_err),
        .err_clr              (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observer on the falling edge: counts handshakes and pulses
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) fbeat = 0;
            if (data_tvalid && data_tready) begin
                n_beats++;
                last_data = data_tdata;
                if (data_tlast != (fbeat == 1023)) n_tlast_bad++;
                if (data_tlast) begin
                    n_tlast++;
                    tlast_cyc = cyc;
                    fbeat = 0;
                end else begin
                    fbeat++;
                end
            end
            if (cfg_tvalid) begin
                n_cfg_cyc++;
                if (cfg_tready) cfg_hist = {cfg_hist[6:0], cfg_tdata};
            end
            if (fwd_done) n_fwd_done++;
            if (inv_done) n_inv_done++;
            if (grant_fwd && grant_inv) n_onehot_bad++;
            if (inv_ready) n_inv_rdy++;
            if (timeout_err && !err_prev) err_cyc = cyc;
            err_prev = timeout_err;
        end
    end

    // Core input ready: constant 1, or toggling every cycle
    initial begin
        forever begin
            @(posedge clk);
            #1 data_tready = tog_en ? ~data_tready : 1'b1;
        end
    end

    // Core output model: after the last input beat, two plain output beats then tlast
    initial begin
        forever begin
            @(negedge clk);
            if (data_tvalid && data_tready && data_tlast && !core_mute) begin
                repeat (3) @(posedge clk);
                #1 xk_tvalid = 1'b1; xk_tlast = 1'b0;
                repeat (2) @(posedge clk);
                #1 xk_tlast = 1'b1;
                @(posedge clk);
                #1 xk_tvalid = 1'b0; xk_tlast = 1'b0;
            end
        end
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic snap();
        s_beats = n_beats; s_tlast = n_tlast; s_tlast_bad = n_tlast_bad; s_cfg = n_cfg_cyc;
        s_fwd = n_fwd_done; s_inv = n_inv_done; s_onehot = n_onehot_bad; s_invrdy = n_inv_rdy;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Waits for a done pulse; optionally drops both requests during DONE; returns one cycle later
    task automatic wait_done(input bit drop, output bit fwd_seen);
        int n = 0;
        fwd_seen = 1'b0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(fwd_done || inv_done) && n < 5000);
        if (n >= 5000) chk("done_wait_expired", 64'd0, 64'd1);
        fwd_seen = fwd_done;
        if (drop) begin
            fwd_req = 1'b0;
            inv_req = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_beats(input int target);
        int n = 0;
        while ((n_beats - s_beats) < target && n < 4000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 4000) chk("beat_wait_expired", 64'd0, 64'd1);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk); #1;
        chk("reset_outs", {cfg_tvalid, cfg_tdata, data_tvalid, data_tlast, fwd_ready, inv_ready,
                           grant_fwd, grant_inv, fwd_done, inv_done, timeout_err}, 64'd0);
        chk("reset_tdata", data_tdata, 64'd0);
        chk("reset_frame_cnt", frame_cnt, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Forward only
        cfg_tready = 1'b1; fwd_valid = 1'b1; inv_valid = 1'b1; fwd_req = 1'b1;
        snap();
        wait_done(1'b1, was_fwd);
        chk("fwd_only_done_is_fwd", was_fwd, 64'd1);
        chk("fwd_only_cfg_cycles", n_cfg_cyc - s_cfg, 64'd1);
        chk("fwd_only_cfg_tdata", cfg_hist[0], 64'd1);
        chk("fwd_only_beats", n_beats - s_beats, 64'd1024);
        chk("fwd_only_tlast_cnt", n_tlast - s_tlast, 64'd1);
        chk("fwd_only_tlast_pos", n_tlast_bad - s_tlast_bad, 64'd0);
        chk("fwd_only_done_pulses", n_fwd_done - s_fwd, 64'd1);
        chk("fwd_only_sign_ext", last_data, 64'hFFFF8001_00007FFE);
        chk("fwd_only_inv_ready", n_inv_rdy - s_invrdy, 64'd0);
        chk("fwd_only_frame_cnt", frame_cnt, 64'd1);

        // Both requesting for four jobs: round-robin
        do_reset();
        fwd_req = 1'b1; inv_req = 1'b1;
        snap();
        order = '0;
        for (int j = 0; j < 4; j++) begin
            wait_done(j == 3, was_fwd);
            order = {order[2:0], was_fwd};
        end
        chk("rr_grant_order", order, 64'b1010);
        chk("rr_cfg_tdata_seq", cfg_hist[3:0], 64'b1010);
        chk("rr_inv_done_pulses", n_inv_done - s_inv, 64'd2);
        chk("rr_onehot", n_onehot_bad - s_onehot, 64'd0);
        chk("rr_inv_sign_ext", last_data, 64'h00001234_FFFFFFFF);
        chk("rr_frame_cnt", frame_cnt, 64'd2);

        // Backpressure and a 10-cycle valid gap; inverse served last so forward wins the tie
        tog_en = 1'b1; fwd_req = 1'b1; inv_req = 1'b1;
        snap();
        wait_beats(500);
        fwd_valid = 1'b0;
        s_tlast = n_beats;
        repeat (10) @(posedge clk);
        #1;
        chk("bp_gap_stall", n_beats - s_tlast, 64'd0);
        fwd_valid = 1'b1;
        s_tlast = n_tlast;
        wait_done(1'b1, was_fwd);
        tog_en = 1'b0;
        chk("bp_granted_fwd", was_fwd, 64'd1);
        chk("bp_beats", n_beats - s_beats, 64'd1024);
        chk("bp_tlast_cnt", n_tlast - s_tlast, 64'd1);
        chk("bp_tlast_pos", n_tlast_bad - s_tlast_bad, 64'd0);
        chk("bp_inv_ready", n_inv_rdy - s_invrdy, 64'd0);
        chk("bp_frame_cnt", frame_cnt, 64'd3);

        // Timeout: core never returns tlast; request dropped mid-job is ignored
        core_mute = 1'b1; fwd_req = 1'b1;
        snap();
        begin
            int n = 0;
            while (n_tlast == s_tlast && n < 3000) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 3000) chk("tmo_tlast_wait_expired", 64'd0, 64'd1);
        end
        fwd_req = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("tmo_grant_held", grant_fwd, 64'd1);
        begin
            int n = 0;
            while (!timeout_err && n < 6000) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 6000) chk("tmo_err_wait_expired", 64'd0, 64'd1);
        end
        @(posedge clk); #1;
        chk("tmo_latency", err_cyc - tlast_cyc, 64'd4097);
        chk("tmo_no_done", n_fwd_done - s_fwd, 64'd0);
        chk("tmo_back_idle", {grant_fwd, grant_inv}, 64'd0);
        chk("tmo_frame_cnt", frame_cnt, 64'd3);
        chk("tmo_err_sticky", timeout_err, 64'd1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("tmo_err_cleared", timeout_err, 64'd0);
        core_mute = 1'b0;

        // Reset mid-LOAD at beat 500, then a clean restart
        fwd_req = 1'b1;
        snap();
        wait_beats(500);
        rst = 1'b1;
        #1;
        chk("rst_async_outs", {cfg_tvalid, data_tvalid, fwd_ready, grant_fwd, grant_inv, timeout_err}, 64'd0);
        chk("rst_async_frame_cnt", frame_cnt, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        snap();
        wait_done(1'b1, was_fwd);
        chk("rst_restart_cfg", n_cfg_cyc - s_cfg, 64'd1);
        chk("rst_restart_beats", n_beats - s_beats, 64'd1024);
        chk("rst_restart_tlast_pos", n_tlast_bad - s_tlast_bad, 64'd0);
        chk("rst_restart_frame_cnt", frame_cnt, 64'd1);

        // Frame counter wrap over 45 forward jobs
        do_reset();
        fwd_req = 1'b1;
        for (int j = 1; j <= 45; j++) begin
            wait_done(j == 45, was_fwd);
            if (j == 44) chk("wrap_frame_cnt_44", frame_cnt, 64'd44);
        end
        chk("wrap_frame_cnt_0", frame_cnt, 64'd0);
        chk("wrap_onehot", n_onehot_bad, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fft_job_scheduler.md
Name: fft_job_scheduler

Overview:
- Shares the single FFT/IFFT core between two requesters: forward path (spectrum display) and inverse path (audio resynthesis).
- Per job: selects a requester, sends the core's 1-bit direction config, streams exactly FFT_LEN input samples, then waits for the core's output frame to finish.
- Maintains the displayed frame counter consumed by the spectrum display block.
- Sits between the audio sample buffers and the FFT core; the core's output stream goes directly to the display RAM writer.

Parameters:
FFT_LEN, 1024, samples per job
LEN_BITS, 10, log2(FFT_LEN)
DATA_W, 16, signed sample width per component
FRAME_CNT_W, 6, frame counter width
FRAME_CNT_MAX, 44, last frame_cnt value before wrapping to 0
TIMEOUT, 4096, max cycles in WAIT_OUT

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
fwd_req  in  1  forward job request, level, held until fwd_done
fwd_valid  in  1  forward sample valid
fwd_data  in  2*DATA_W  {imag, real} signed
fwd_ready  out  1  forward sample accepted
inv_req  in  1  inverse job request, level, held until inv_done
inv_valid  in  1  inverse sample valid
inv_data  in  2*DATA_W  {imag, real} signed
inv_ready  out  1  inverse sample accepted
xn_axi4s_cfg_tvalid  out  1  core config valid
xn_axi4s_cfg_tdata  out  1  1 = FFT, 0 = IFFT
xn_axi4s_cfg_tready  in  1  core config ready
xn_axi4s_data_tvalid  out  1  core input valid
xn_axi4s_data_tdata  out  64  real sign-extended in [31:0], imag in [63:32]
xn_axi4s_data_tlast  out  1  last input sample
xn_axi4s_data_tready  in  1  core input ready
xk_axi4s_data_tvalid  in  1  core output valid
xk_axi4s_data_tlast  in  1  core output last
grant_fwd  out  1  forward job active (CFG through DONE)
grant_inv  out  1  inverse job active (CFG through DONE)
fwd_done  out  1  one-cycle pulse, forward job complete
inv_done  out  1  one-cycle pulse, inverse job complete
frame_cnt  out  FRAME_CNT_W  count of completed forward jobs, wraps
timeout_err  out  1  sticky; set on WAIT_OUT timeout
err_clr  in  1  clears timeout_err

Behaviour:
- Reset values: all outputs 0, state IDLE, last_served = INV so forward wins the first tie.
- IDLE → CFG when any request is present.
  - Only one requesting: grant it.
  - Both requesting: grant the one not equal to last_served (round-robin).
  - Grant is latched on this transition.
- CFG:
  - cfg_tvalid = 1; cfg_tdata = 1 for forward, 0 for inverse.
  - Both held stable until cfg_tready. Handshake cycle → LOAD, cfg_tvalid = 0 next cycle.
- LOAD:
  - Combinational pass-through: data_tvalid = granted valid; granted ready = data_tready; tdata = granted data, each component sign-extended to 32 bits.
  - Non-granted ready = 0.
  - sample_cnt (LEN_BITS) increments on each accepted beat (valid & ready).
  - tlast = 1 while sample_cnt == FFT_LEN-1.
  - The accepted beat with count FFT_LEN-1 → WAIT_OUT; sample_cnt returns to 0.
  - A requester dropping valid mid-frame only stalls; the frame is never truncated.
- WAIT_OUT:
  - tmo_cnt increments every cycle.
  - xk_tvalid & xk_tlast → DONE. Output beats before tlast are ignored.
  - tmo_cnt == TIMEOUT-1 without tlast → timeout_err = 1, go to IDLE, no done pulse, last_served updated.
- DONE (one cycle):
  - Pulse fwd_done or inv_done; set last_served.
  - Forward jobs only: frame_cnt increments, wrapping FRAME_CNT_MAX → 0.
  - Then IDLE; a new grant is possible on the next cycle.
- grant_* is high from CFG entry through DONE inclusive, and is one-hot.
- Request deassertion during a job is ignored; the job runs to completion.
- err_clr clears timeout_err. If err_clr and a timeout occur in the same cycle, set wins.
- rst mid-job aborts immediately: cfg/data valids drop asynchronously, counters clear, frame_cnt returns to 0.

Optional Feature:
FFT_SCHED_FWD_PRIORITY_EN
- Defined: fixed priority; forward always wins a tie, and last_served is unused for arbitration.
- Undefined: round-robin as above.

Test Plan:
- Forward only: fwd_req = 1, cfg_tready = 1, data_tready = 1, 1024 beats → cfg_tdata = 1 for exactly 1 cycle; tlast on beat 1024; after xk_tlast, fwd_done pulses once; frame_cnt 0 → 1.
- Both requests held for 4 jobs → grant order FWD, INV, FWD, INV; cfg_tdata sequence 1, 0, 1, 0; frame_cnt ends at 2.
- Backpressure: data_tready toggles every cycle and fwd_valid is dropped for 10 cycles mid-frame → exactly 1024 accepted beats, tlast on the last only, inv_ready stays 0.
- Wrap: 45 forward jobs → frame_cnt reads 44 after 44 jobs and 0 after the 45th.
- Timeout: no xk_tlast → timeout_err = 1 at 4096 cycles after WAIT_OUT entry, no fwd_done, return to IDLE; err_clr clears it.
- Reset mid-LOAD at beat 500 → all outputs 0; the next job restarts from CFG with sample_cnt = 0.
